decode_stage: RTL and testbench
===============================

# decode_stage

Registered instruction-decode stage for the 16-bit Harvard core. It accepts 32-bit instruction words from fetch over a valid/ready handshake and extracts the opcode, register, immediate and address fields into a one-deep output pipeline register. A register scoreboard tracks pending writes and stalls on RAW/WAW hazards until writeback clears them. The block sits between fetch and the ALU/memory issue logic, and generalises the former combinational field mux with parametrised opcode range, writeback port count and hazard mode.

## Interface
- LAST_OP, 17: highest legal opcode; ALU class spans opcodes 4..LAST_OP (LAST_OP ≥ 4, ≤ 63).
- NUM_WB, 2: number of independent writeback-clear ports (1..4).
- SB_EN, 1: 1 = scoreboard stalls enabled; 0 = no pending tracking, no hazard stalls.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts this cycle (combinational).
- in_instr  in  32  instruction word; opcode is [31:26].
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  issue consumes the bundle.
- out_op  out  6  opcode.
- out_class  out  3  0 LDI, 1 MOV, 2 LD, 3 ST, 4 ALU, 7 ILLEGAL.
- out_rd2, out_rd1, out_rs2, out_rs1  out  5 each  register indices.
- out_wen2, out_wen1  out  1 each  destination write enables.
- out_imm  out  16  immediate (LDI).
- out_addr  out  8  memory address (LD/ST).
- out_illegal  out  1  illegal instruction flag.
- wb_valid  in  NUM_WB  per-port writeback strobe.
- wb_idx  in  5*NUM_WB  per-port register index; port k uses [5k+4:5k].
- flush  in  1  drop the bundle and clear the scoreboard.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

## Operation
- Field extraction (unused fields are driven 0):
  - op 0 LDI: rd2 = [25:21], imm = [15:0], wen2 = 1.
  - op 1 MOV: rd2 = [25:21], rs2 = [4:0], wen2 = 1.
  - op 2 LD: rd2 = [25:21], addr = [7:0], wen2 = 1.
  - op 3 ST: addr = [25:18], rs2 = [4:0], no write enables.
  - ALU (4..LAST_OP): rd2 = [25:21], rd1 = [20:16], rs2 = [9:5], rs1 = [4:0], wen2 = wen1 = 1.
- Illegal instructions:
  - Conditions: opcode > LAST_OP, or an ALU instruction with rd2 == rd1.
  - Result: class 7, out_illegal = 1, all index/imm/addr fields and write enables 0, scoreboard not touched.
  - Illegal instructions never stall.
- Scoreboard: 32-bit pending vector, one bit per register.
  - Hazard when any source read (MOV/ST: rs2; ALU: rs2, rs1) or any enabled destination has its pending bit set.
  - Hazard is evaluated against the registered pending vector only.
- Handshake: in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Accept (in_valid & in_ready) on a rising edge:
  - Load the output register; set out_valid = 1.
  - Set the pending bits of the enabled destinations.
- Output drain: when out_valid & out_ready and nothing is accepted, out_valid goes to 0.
- Writeback: wb_valid[k] clears pending[wb_idx[k]] at the edge.
  - Set and clear of the same index in one edge: set wins.
  - Duplicate clears of one index are harmless.
- Flush (highest priority at an edge):
  - Sets out_valid = 0 and pending = 0.
  - Overrides any simultaneous accept, which is impossible anyway because in_ready is 0.
- stall_cnt: increments on each cycle with in_valid & hazard & !flush; saturates at 0xFFFF; not cleared by flush.
- SB_EN = 0: hazard is tied to 0 and the pending vector is held at 0.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction per cycle when out_ready = 1 and no hazard.
- Output stability: out_* stay stable while out_valid & !out_ready.
- in_ready is combinational from out_valid, out_ready, the pending register, in_instr and flush; it has no dependence on wb_*.
- Writeback clear latency: a clear at edge N makes in_ready = 1 in cycle N+1.
- Reset (rst_n low, asynchronous):
  - out_valid, all out_* fields, pending and stall_cnt go to 0.
  - in_ready = 1 after reset when flush = 0.
- Reset during a stall discards the in-flight bundle; fetch must re-present the instruction.

## Test plan
- Reset and LDI: reset, then send 0x0020BEEF → next cycle out_valid = 1, class 0, rd2 = 1, imm = 0xBEEF, wen2 = 1; pending[1] = 1.
- RAW stall: after the LDI above, send MOV 0x04A00001 (rd2 = 5, rs2 = 1) → in_ready = 0 and stall_cnt increments each cycle; assert wb_valid[0] with wb_idx = 1 → in_ready = 1 in the next cycle; MOV is accepted with rd2 = 5.
- Dual-destination ALU: send 0x10640022 → class 4, rd2 = 3, rd1 = 4, rs2 = 1, rs1 = 2; pending[3] and pending[4] set; clear both in the same cycle on ports 0 and 1 → both bits 0.
- Illegal instructions: 0x48000000 (opcode 18) → class 7, out_illegal = 1, no stall, pending unchanged. An ALU instruction with rd2 = rd1 = 3 → illegal.
- Backpressure and ST: hold out_ready = 0 and send ST 0x0D680003 → out_addr = 0x5A, rs2 = 3, held stable; the next instruction waits with in_ready = 0 until out_ready = 1.
- Flush and saturation:
  - Flush with out_valid = 1 and pending non-zero → out_valid = 0 and pending = 0 next cycle.
  - Force 70000 stall cycles → stall_cnt = 0xFFFF.

Source files
------------

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: field extraction into a one-deep output
// register, with a pending-write scoreboard that stalls fetch on RAW/WAW hazards.
module decode_stage #(
    parameter int LAST_OP = 17,
    parameter int NUM_WB  = 2,
    parameter int SB_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            out_op,
    output logic [2:0]            out_class,
    output logic [4:0]            out_rd2,
    output logic [4:0]            out_rd1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rs1,
    output logic                  out_wen2,
    output logic                  out_wen1,
    output logic [15:0]           out_imm,
    output logic [7:0]            out_addr,
    output logic                  out_illegal,
    input  logic [NUM_WB-1:0]     wb_valid,
    input  logic [5*NUM_WB-1:0]   wb_idx,
    input  logic                  flush,
    output logic [15:0]           stall_cnt
);

    typedef enum logic [2:0] {
        CLS_LDI = 3'd0,
        CLS_MOV = 3'd1,
        CLS_LD  = 3'd2,
        CLS_ST  = 3'd3,
        CLS_ALU = 3'd4,
        CLS_ILL = 3'd7
    } cls_e;

    typedef struct packed {
        logic [5:0]  op;
        cls_e        cls;
        logic [4:0]  rd2;
        logic [4:0]  rd1;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic        wen2;
        logic        wen1;
        logic [15:0] imm;
        logic [7:0]  addr;
        logic        illegal;
    } bundle_t;

    localparam logic [5:0] LAST_OP_L = 6'(LAST_OP);

    bundle_t     dec;
    bundle_t     bundle_d, bundle_q;
    logic        rd_rs2, rd_rs1;
    logic        hazard, accept;
    logic        out_valid_d, out_valid_q;
    logic [31:0] pending_d, pending_q;
    logic [15:0] stall_cnt_d, stall_cnt_q;

    // Illegal encodings leave every index/enable at zero, so they can never hazard.
    always_comb begin
        dec         = '0;
        rd_rs2      = 1'b0;
        rd_rs1      = 1'b0;
        dec.op      = in_instr[31:26];
        dec.cls     = CLS_ILL;
        dec.illegal = 1'b1;
        case (in_instr[31:26])
            6'd0: begin
                dec.cls = CLS_LDI; dec.illegal = 1'b0;
                dec.rd2 = in_instr[25:21]; dec.imm = in_instr[15:0]; dec.wen2 = 1'b1;
            end
            6'd1: begin
                dec.cls = CLS_MOV; dec.illegal = 1'b0;
                dec.rd2 = in_instr[25:21]; dec.rs2 = in_instr[4:0]; dec.wen2 = 1'b1;
                rd_rs2  = 1'b1;
            end
            6'd2: begin
                dec.cls = CLS_LD; dec.illegal = 1'b0;
                dec.rd2 = in_instr[25:21]; dec.addr = in_instr[7:0]; dec.wen2 = 1'b1;
            end
            6'd3: begin
                dec.cls = CLS_ST; dec.illegal = 1'b0;
                dec.addr = in_instr[25:18]; dec.rs2 = in_instr[4:0];
                rd_rs2   = 1'b1;
            end
            default: begin
                if (in_instr[31:26] <= LAST_OP_L && in_instr[25:21] != in_instr[20:16]) begin
                    dec.cls = CLS_ALU; dec.illegal = 1'b0;
                    dec.rd2 = in_instr[25:21]; dec.rd1 = in_instr[20:16];
                    dec.rs2 = in_instr[9:5];   dec.rs1 = in_instr[4:0];
                    dec.wen2 = 1'b1; dec.wen1 = 1'b1;
                    rd_rs2 = 1'b1; rd_rs1 = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        hazard = (SB_EN != 0) &&
                 ((dec.wen2 && pending_q[dec.rd2]) || (dec.wen1 && pending_q[dec.rd1]) ||
                  (rd_rs2 && pending_q[dec.rs2])   || (rd_rs1 && pending_q[dec.rs1]));
        in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        pending_d   = pending_q;
        stall_cnt_d = stall_cnt_q;

        if (accept) begin
            bundle_d    = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clears first so a same-edge set on the same index wins.
        for (int unsigned k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k]) pending_d[wb_idx[5*k +: 5]] = 1'b0;
        end
        if (accept && dec.wen2) pending_d[dec.rd2] = 1'b1;
        if (accept && dec.wen1) pending_d[dec.rd1] = 1'b1;

        if (flush) begin
            out_valid_d = 1'b0;
            pending_d   = '0;
        end
        if (SB_EN == 0) pending_d = '0;

        if (in_valid && hazard && !flush && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
            pending_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op      = bundle_q.op;
    assign out_class   = bundle_q.cls;
    assign out_rd2     = bundle_q.rd2;
    assign out_rd1     = bundle_q.rd1;
    assign out_rs2     = bundle_q.rs2;
    assign out_rs1     = bundle_q.rs1;
    assign out_wen2    = bundle_q.wen2;
    assign out_wen1    = bundle_q.wen1;
    assign out_imm     = bundle_q.imm;
    assign out_addr    = bundle_q.addr;
    assign out_illegal = bundle_q.illegal;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table, hand-written hazard/backpressure/
// flush/saturation sequences, and a randomized run against a reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, flush;
    logic [31:0] in_instr;
    logic [5:0]  out_op;
    logic [2:0]  out_class;
    logic [4:0]  out_rd2, out_rd1, out_rs2, out_rs1;
    logic        out_wen2, out_wen1, out_illegal;
    logic [15:0] out_imm, stall_cnt;
    logic [7:0]  out_addr;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_idx;

    always #5 clk = ~clk;

    decode_stage #(.LAST_OP(17), .NUM_WB(2), .SB_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_class(out_class), .out_rd2(out_rd2), .out_rd1(out_rd1),
        .out_rs2(out_rs2), .out_rs1(out_rs1), .out_wen2(out_wen2), .out_wen1(out_wen1),
        .out_imm(out_imm), .out_addr(out_addr), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .flush(flush), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [5:0]  op;
        logic [2:0]  cls;
        logic [4:0]  rd2, rd1, rs2, rs1;
        logic        w2, w1;
        logic [15:0] imm;
        logic [7:0]  addr;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        dec_t        exp;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic dec_t mk(int op, int cls, int rd2, int rd1, int rs2, int rs1,
                                int w2, int w1, int imm, int addr, int ill);
        dec_t d;
        d.op = 6'(op); d.cls = 3'(cls); d.rd2 = 5'(rd2); d.rd1 = 5'(rd1);
        d.rs2 = 5'(rs2); d.rs1 = 5'(rs1); d.w2 = 1'(w2); d.w1 = 1'(w1);
        d.imm = 16'(imm); d.addr = 8'(addr); d.ill = 1'(ill);
        return d;
    endfunction

    function automatic dec_t dut_out();
        dec_t d;
        d.op = out_op; d.cls = out_class; d.rd2 = out_rd2; d.rd1 = out_rd1;
        d.rs2 = out_rs2; d.rs1 = out_rs1; d.w2 = out_wen2; d.w1 = out_wen1;
        d.imm = out_imm; d.addr = out_addr; d.ill = out_illegal;
        return d;
    endfunction

    // Reference decode straight from the instruction-format table
    function automatic dec_t ref_dec(logic [31:0] i);
        int op;
        op = int'(i[31:26]);
        if (op > 17 || (op >= 4 && i[25:21] == i[20:16])) return mk(op, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        case (op)
            0:       return mk(op, 0, i[25:21], 0, 0, 0, 1, 0, i[15:0], 0, 0);
            1:       return mk(op, 1, i[25:21], 0, i[4:0], 0, 1, 0, 0, 0, 0);
            2:       return mk(op, 2, i[25:21], 0, 0, 0, 1, 0, 0, i[7:0], 0);
            3:       return mk(op, 3, 0, 0, i[4:0], 0, 0, 0, 0, i[25:18], 0);
            default: return mk(op, 4, i[25:21], i[20:16], i[9:5], i[4:0], 1, 1, 0, 0, 0);
        endcase
    endfunction

    function automatic bit ref_hz(dec_t d, logic [31:0] p);
        int regs[$];
        if (d.ill) return 0;
        if (d.w2) regs.push_back(int'(d.rd2));
        if (d.w1) regs.push_back(int'(d.rd1));
        if (d.cls inside {3'd1, 3'd3, 3'd4}) regs.push_back(int'(d.rs2));
        if (d.cls == 3'd4) regs.push_back(int'(d.rs1));
        foreach (regs[j]) if (p[regs[j]]) return 1;
        return 0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_valid = '0; wb_idx = '0; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    vec_t   tbl[9];
    dec_t   md, hold;
    logic   rdy, m_valid;
    logic [31:0] m_pend, np;
    int     m_stall;
    dec_t   m_out;

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_fields", dut_out(), 0);
        chk("reset_pending", dut.pending_q, 0);
        chk("reset_stall_cnt", stall_cnt, 0);
        chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        cyc();

        tbl[0] = '{32'h0020BEEF, mk(0, 0, 1, 0, 0, 0, 1, 0, 16'hBEEF, 0, 0)};
        tbl[1] = '{32'h04A00001, mk(1, 1, 5, 0, 1, 0, 1, 0, 0, 0, 0)};
        tbl[2] = '{32'h08E000A5, mk(2, 2, 7, 0, 0, 0, 1, 0, 0, 8'hA5, 0)};
        tbl[3] = '{32'h0D680003, mk(3, 3, 0, 0, 3, 0, 0, 0, 0, 8'h5A, 0)};
        tbl[4] = '{32'h10640022, mk(4, 4, 3, 4, 1, 2, 1, 1, 0, 0, 0)};
        tbl[5] = '{32'h444903E0, mk(17, 4, 2, 9, 31, 0, 1, 1, 0, 0, 0)};
        tbl[6] = '{32'h48000000, mk(18, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        tbl[7] = '{32'h10630022, mk(4, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        tbl[8] = '{32'hFC000000, mk(63, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        foreach (tbl[v]) begin
            do_flush();
            in_valid = 1'b1; in_instr = tbl[v].instr;
            #1;
            chk($sformatf("tbl%0d_in_ready", v), in_ready, 1);
            cyc();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_out_valid", v), out_valid, 1);
            chk($sformatf("tbl%0d_fields", v), dut_out(), tbl[v].exp);
        end

        // RAW stall on r1, released by writeback port 0
        do_flush();
        in_valid = 1'b1; in_instr = 32'h0020BEEF;
        cyc();
        chk("ldi_pending", dut.pending_q, 32'h2);
        in_instr = 32'h04A00001;
        #1;
        chk("raw_in_ready", in_ready, 0);
        repeat (3) cyc();
        chk("raw_stall_cnt", stall_cnt, 3);
        wb_valid = 2'b01; wb_idx = {5'd0, 5'd1};
        #1;
        chk("raw_ready_no_wb_path", in_ready, 0);
        cyc();
        wb_valid = '0;
        chk("raw_release_ready", in_ready, 1);
        chk("raw_stall_cnt2", stall_cnt, 4);
        cyc();
        in_valid = 1'b0;
        chk("mov_fields", dut_out(), mk(1, 1, 5, 0, 1, 0, 1, 0, 0, 0, 0));
        chk("mov_pending", dut.pending_q, 32'h20);

        // Dual destination, both cleared in one edge
        in_valid = 1'b1; in_instr = 32'h10640022;
        #1;
        chk("alu_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        chk("alu_fields", dut_out(), mk(4, 4, 3, 4, 1, 2, 1, 1, 0, 0, 0));
        chk("alu_pending", dut.pending_q, 32'h38);
        wb_valid = 2'b11; wb_idx = {5'd4, 5'd3};
        cyc();
        wb_valid = '0;
        chk("dual_clear_pending", dut.pending_q, 32'h20);

        // Illegal ALU touching pending r5 must not stall
        in_valid = 1'b1; in_instr = 32'h10A50000;
        #1;
        chk("ill_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        chk("ill_fields", dut_out(), mk(4, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("ill_pending", dut.pending_q, 32'h20);

        // Backpressure holding an ST bundle
        in_valid = 1'b1; in_instr = 32'h0D680003;
        cyc();
        out_ready = 1'b0;
        in_instr = 32'h0020BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            cyc();
            chk("bp_hold", dut_out(), mk(3, 3, 0, 0, 3, 0, 0, 0, 0, 8'h5A, 0));
            chk("bp_valid", out_valid, 1);
        end
        chk("bp_no_stall_count", stall_cnt, 4);
        out_ready = 1'b1;
        #1;
        chk("bp_release", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        chk("bp_next", dut_out(), mk(0, 0, 1, 0, 0, 0, 1, 0, 16'hBEEF, 0, 0));

        // Flush with a held bundle and pending bits
        out_ready = 1'b0; flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        cyc();
        flush = 1'b0; out_ready = 1'b1;
        chk("flush_valid", out_valid, 0);
        chk("flush_pending", dut.pending_q, 0);

        // Randomized run against the reference model
        idle();
        do_reset();
        m_valid = 0; m_pend = '0; m_stall = 0; m_out = '0;
        for (int n = 0; n < 3000; n++) begin
            int r, op;
            r = $urandom_range(0, 9);
            if (r < 4)      op = $urandom_range(0, 3);
            else if (r < 8) op = $urandom_range(4, 17);
            else            op = $urandom_range(18, 63);
            in_instr = $urandom;
            in_instr[31:26] = 6'(op);
            in_instr[25:21] = 5'($urandom_range(0, 7));
            in_instr[20:16] = 5'($urandom_range(0, 7));
            in_instr[9:5]   = 5'($urandom_range(0, 7));
            in_instr[4:0]   = 5'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            wb_valid  = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            wb_idx    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #1;
            md  = ref_dec(in_instr);
            rdy = (!m_valid || out_ready) && !ref_hz(md, m_pend) && !flush;
            chk("rnd_in_ready", in_ready, rdy);
            if (in_valid && ref_hz(md, m_pend) && !flush && m_stall < 65535) m_stall++;
            np = m_pend;
            for (int k = 0; k < 2; k++) if (wb_valid[k]) np[wb_idx[5*k +: 5]] = 1'b0;
            if (in_valid && rdy) begin
                if (md.w2) np[md.rd2] = 1'b1;
                if (md.w1) np[md.rd1] = 1'b1;
                m_out = md; m_valid = 1;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (flush) begin
                m_valid = 0; np = '0;
            end
            m_pend = np;
            cyc();
            chk("rnd_out_valid", out_valid, m_valid);
            chk("rnd_pending", dut.pending_q, m_pend);
            chk("rnd_stall_cnt", stall_cnt, m_stall);
            if (m_valid) chk("rnd_fields", dut_out(), m_out);
        end

        // Saturation of the stall counter
        idle();
        do_flush();
        in_valid = 1'b1; in_instr = 32'h0020BEEF;
        cyc();
        in_instr = 32'h04A00001;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
        in_valid = 1'b0;
        do_flush();
        chk("sat_kept_by_flush", stall_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
